pipe_hazard_ctrl: RTL and testbench

- Parametrised next-generation hazard/control unit for the 5-stage Y86-64 pipeline (F, D, E, M, W).
- Computes per-stage stall and bubble controls from the decode, execute, memory and writeback stage fields.
- Adds three things over the current unit: a configurable register-ID width and "no register" code, a sticky HALTED state machine entered on a writeback exception, and optional saturating hazard-event counters.
- Control outputs are combinational in the current cycle so the pipeline registers see them at the next clk edge.

---
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for the 5-stage Y86-64 pipeline: stall/bubble controls, sticky HALTED FSM.
// Optional saturating event counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned          REG_W    = 4,
   parameter logic [REG_W-1:0]     RNONE    = REG_W'(4'hF),
   parameter int unsigned          STAT_W   = 4,
   parameter logic [STAT_W-1:0]    STAT_AOK = STAT_W'(1),
   parameter int unsigned          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        E_icode,
   input  logic [3:0]        M_icode,
   input  logic [REG_W-1:0]  d_srcA,
   input  logic [REG_W-1:0]  d_srcB,
   input  logic [REG_W-1:0]  E_dstM,
   input  logic              e_Cnd,
   input  logic [STAT_W-1:0] m_stat,
   input  logic [STAT_W-1:0] W_stat,
   output logic              F_stall,
   output logic              D_stall,
   output logic              D_bubble,
   output logic              E_bubble,
   output logic              M_bubble,
   output logic              W_stall,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  ret_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam logic [3:0] IMrmovq = 4'h5;
   localparam logic [3:0] IPopq   = 4'hB;
   localparam logic [3:0] IJxx    = 4'h7;
   localparam logic [3:0] IRet    = 4'h9;

   typedef enum logic {StRun, StHalted} state_t;

   state_t state_q, state_d;
   logic   load_use, ret_in, mispred, m_exc, w_exc, ret_ev;

   always_comb begin
      load_use = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_in   = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
      mispred  = (E_icode == IJxx) && !e_Cnd;
      m_exc    = (m_stat != STAT_AOK);
      w_exc    = (W_stat != STAT_AOK);
      ret_ev   = ret_in && !load_use;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StRun;
      else          state_q <= state_d;
   end

   // Controls are gated by reset_n directly so they drop to 0 while reset is held.
   always_comb begin
      state_d  = state_q;
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      halted   = (state_q == StHalted);
      if (reset_n) begin
         unique case (state_q)
            StRun: begin
               F_stall  = load_use | ret_in;
               D_stall  = load_use;
               D_bubble = mispred | ret_ev;
               E_bubble = mispred | load_use;
               M_bubble = m_exc | w_exc;
               W_stall  = w_exc;
               if (w_exc) state_d = StHalted;
            end
            StHalted: begin
               F_stall  = 1'b1;
               D_stall  = 1'b1;
               M_bubble = 1'b1;
               W_stall  = 1'b1;
            end
            default: state_d = StRun;
         endcase
      end
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, ret_cnt_q, mispred_cnt_q;
   logic             run;

   assign run = (state_q == StRun);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q   <= '0;
         ret_cnt_q     <= '0;
         mispred_cnt_q <= '0;
      end else if (run) begin
         if (load_use && (stall_cnt_q != '1))  stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
         if (ret_ev && (ret_cnt_q != '1))      ret_cnt_q     <= ret_cnt_q + CNT_W'(1);
         if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign ret_cnt     = ret_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`else
   assign stall_cnt   = '0;
   assign ret_cnt     = '0;
   assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a 16-bit-counter instance and a 2-bit-counter instance
// share the same directed stimulus; expected responses are queued and checked by a monitor.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       reset_n;
   logic [3:0] D_icode, E_icode, M_icode;
   logic [3:0] d_srcA, d_srcB, E_dstM;
   logic       e_Cnd;
   logic [3:0] m_stat, W_stat;

   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
   logic [15:0] stall_cnt, ret_cnt, mispred_cnt;
   logic        F_stall2, D_stall2, D_bubble2, E_bubble2, M_bubble2, W_stall2, halted2;
   logic [1:0]  stall_cnt2, ret_cnt2, mispred_cnt2;

   typedef struct {
      logic [5:0]  ctrl;
      logic        h;
      logic [15:0] s, r, m;
      logic [1:0]  s2, r2, m2;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_no = 0;

   pipe_hazard_ctrl #(.CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted),
      .stall_cnt(stall_cnt), .ret_cnt(ret_cnt), .mispred_cnt(mispred_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall2), .D_stall(D_stall2), .D_bubble(D_bubble2), .E_bubble(E_bubble2),
      .M_bubble(M_bubble2), .W_stall(W_stall2), .halted(halted2),
      .stall_cnt(stall_cnt2), .ret_cnt(ret_cnt2), .mispred_cnt(mispred_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int n, input logic [15:0] act,
                      input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %0h expected %0h", n, name, act, exp);
      end
   endtask

   // Monitor: the DUT presents a fresh response every cycle; check it on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [15:0] es, er, em;
         logic [1:0]  es2, er2, em2;
         e = exp_q.pop_front();
`ifdef PIPE_HAZARD_PERF_CNT_EN
         es = e.s;  er = e.r;  em = e.m;  es2 = e.s2; er2 = e.r2; em2 = e.m2;
`else
         es = '0;   er = '0;   em = '0;   es2 = '0;  er2 = '0;  em2 = '0;
`endif
         chk("ctrl", step_no, {10'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall},
             {10'd0, e.ctrl});
         chk("ctrl2", step_no,
             {10'd0, F_stall2, D_stall2, D_bubble2, E_bubble2, M_bubble2, W_stall2},
             {10'd0, e.ctrl});
         chk("halted", step_no, {14'd0, halted2, halted}, {14'd0, e.h, e.h});
         chk("stall_cnt", step_no, stall_cnt, es);
         chk("ret_cnt", step_no, ret_cnt, er);
         chk("mispred_cnt", step_no, mispred_cnt, em);
         chk("cnt_w2", step_no, {10'd0, stall_cnt2, ret_cnt2, mispred_cnt2},
             {10'd0, es2, er2, em2});
         step_no++;
      end
   end

   // ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}; counters are the values
   // visible this cycle (events of earlier edges).
   task automatic step(input logic rst, input logic [3:0] di, ei, mi, sa, sb, dm,
                       input logic cnd, input logic [3:0] ms, ws,
                       input logic [5:0] ctrl, input logic h,
                       input int s, r, m, s2, r2, m2);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = rst;
      D_icode = di; E_icode = ei; M_icode = mi;
      d_srcA = sa;  d_srcB = sb;  E_dstM = dm;
      e_Cnd = cnd;  m_stat = ms;  W_stat = ws;
      e.ctrl = ctrl; e.h = h;
      e.s = 16'(s);  e.r = 16'(r);  e.m = 16'(m);
      e.s2 = 2'(s2); e.r2 = 2'(r2); e.m2 = 2'(m2);
      exp_q.push_back(e);
   endtask

   initial begin
      reset_n = 1'b0;
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
      e_Cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1;
      repeat (2) @(posedge clk);
      //    rst  D    E    M    srcA srcB dstM cnd  mst  wst  ctrl       h   s  r  m  s2 r2 m2
      step(0, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b000000, 0, 0, 0, 0, 0, 0, 0);
      step(1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b000000, 0, 0, 0, 0, 0, 0, 0);
      // load-use on srcB
      step(1, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 0, 0, 0, 0, 0, 0);
      // RNONE never matches
      step(1, 4'h1, 4'hB, 4'h1, 4'hF, 4'h2, 4'hF, 1, 4'h1, 4'h1, 6'b000000, 0, 1, 0, 0, 1, 0, 0);
      // ret walking D -> E -> M
      step(1, 4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b101000, 0, 1, 0, 0, 1, 0, 0);
      step(1, 4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b101000, 0, 1, 1, 0, 1, 1, 0);
      step(1, 4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b101000, 0, 1, 2, 0, 1, 2, 0);
      step(1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b000000, 0, 1, 3, 0, 1, 3, 0);
      // mispredict + ret in D
      step(1, 4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 6'b101100, 0, 1, 3, 0, 1, 3, 0);
      // load-use + ret: stall wins in D; 2-bit ret count already saturated
      step(1, 4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 1, 4, 1, 1, 3, 1);
      step(1, 4'h1, 4'hB, 4'h1, 4'h3, 4'hF, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 2, 4, 1, 2, 3, 1);
      step(1, 4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 3, 4, 1, 3, 3, 1);
      step(1, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 4, 4, 1, 3, 3, 1);
      // memory-stage exception, then writeback exception
      step(1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h3, 4'h1, 6'b000010, 0, 5, 4, 1, 3, 3, 1);
      step(1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h3, 6'b000011, 0, 5, 4, 1, 3, 3, 1);
      // HALTED: forced outputs, counters frozen
      step(1, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b110011, 1, 5, 4, 1, 3, 3, 1);
      step(1, 4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 6'b110011, 1, 5, 4, 1, 3, 3, 1);
      // async reset between edges while HALTED
      step(0, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b000000, 0, 0, 0, 0, 0, 0, 0);
      step(1, 4'h1, 4'h5, 4'h1, 4'hF, 4'h3, 4'h3, 1, 4'h1, 4'h1, 6'b110100, 0, 0, 0, 0, 0, 0, 0);
      step(1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 6'b000000, 0, 1, 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0 || step_no != 20) begin
         n_fail++;
         $display("FAIL drain: checked %0d of 20 responses, %0d left", step_no, exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
